fp_mant_normalizer_pipe: RTL and testbench

//  Left-normalizer for the FP datapath, the counterpart of the right-shift alignment shifter.
//  - Takes a post-add mantissa and its exponent.
//  - Shifts left until MSB=1, reporting the shift count and the adjusted exponent.
//  - Uses log-stage shifting (4/2/1 for W=8), one registered stage per shift level.
//  - Valid/ready handshake on both sides; sits between the mantissa adder and the rounder.

---
 rtl/fp_norm_pkg.sv | 28 ++
 rtl/fp_norm_stage.sv | 98 +++++++++
 rtl/fp_mant_normalizer_pipe.sv | 84 ++++++++
 tb/tb_fp_mant_normalizer_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
`default_nettype none
// ============================================================================
// fp_norm_pkg : default widths, per-stage shift amounts and result record
//               for the mantissa left-normalizer pipeline.
// Rev 1.0
// ============================================================================
package fp_norm_pkg;

  localparam int c_W  = 8;
  localparam int c_EW = 5;
  localparam int c_SW = 3;

  // Stage k shifts by W>>k; stage 1 takes the widest step.
  localparam int c_STAGE_AMT [c_SW] = '{c_W >> 1, c_W >> 2, c_W >> 3};

  typedef struct packed {
    logic [c_W-1:0]  mant;
    logic [c_EW-1:0] exp;
    logic [c_SW-1:0] shift;
    logic            zero;
  } norm_rec_t;

  function automatic int stage_amt(input int w, input int k);
    return w >> k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_stage.sv
`default_nettype none
// ============================================================================
// fp_norm_stage : one conditional left-shift level with its pipeline register
//                 and valid/advance handshake. The LAST instance also folds in
//                 the exponent subtract, clamp and zero detection.
// Rev 1.0
// ============================================================================
module fp_norm_stage #(
  parameter int W    = 8,
  parameter int EW   = 5,
  parameter int SW   = 3,
  parameter int AMT  = 4,
  parameter bit LAST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [W-1:0]  i_mant,
  input  logic [EW-1:0] i_exp,
  input  logic [SW-1:0] i_shift,
  input  logic          i_zero,
  input  logic          i_uflow,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_mant,
  output logic [EW-1:0] o_exp,
  output logic [SW-1:0] o_shift,
  output logic          o_zero,
  output logic          o_uflow
);

  logic          r_valid;
  logic [W-1:0]  r_mant;
  logic [EW-1:0] r_exp;
  logic [SW-1:0] r_shift;
  logic          r_zero;
  logic          r_uflow;

  logic          w_load;
  logic          w_hit;
  logic [W-1:0]  w_mant_nx;
  logic [SW-1:0] w_shift_nx;
  logic [EW-1:0] w_exp_nx;
  logic          w_zero_nx;
  logic          w_uflow_nx;

  assign w_load     = !r_valid || i_ready;
  assign o_ready    = w_load;

  assign w_hit      = (i_mant[W-1 -: AMT] == '0);
  assign w_mant_nx  = w_hit ? (i_mant << AMT) : i_mant;
  assign w_shift_nx = w_hit ? (i_shift + SW'(AMT)) : i_shift;

  generate
    if (LAST) begin : g_last
      logic [EW:0] w_diff;
      // After every level has run, a non-zero mantissa always has its MSB set.
      assign w_diff     = {1'b0, i_exp} - (EW+1)'(w_shift_nx);
      assign w_zero_nx  = i_zero | !w_mant_nx[W-1];
      assign w_uflow_nx = i_uflow | (w_diff[EW] && !w_zero_nx);
      assign w_exp_nx   = (w_diff[EW] || w_zero_nx) ? '0 : w_diff[EW-1:0];
    end else begin : g_mid
      assign w_zero_nx  = i_zero;
      assign w_uflow_nx = i_uflow;
      assign w_exp_nx   = i_exp;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_mant  <= '0;
      r_exp   <= '0;
      r_shift <= '0;
      r_zero  <= 1'b0;
      r_uflow <= 1'b0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_mant  <= w_mant_nx;
        r_exp   <= w_exp_nx;
        r_shift <= w_shift_nx;
        r_zero  <= w_zero_nx;
        r_uflow <= w_uflow_nx;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_mant  = r_mant;
  assign o_exp   = r_exp;
  assign o_shift = r_shift;
  assign o_zero  = r_zero;
  assign o_uflow = r_uflow;

endmodule
`default_nettype wire

// File: rtl/fp_mant_normalizer_pipe.sv
`default_nettype none
// ============================================================================
// fp_mant_normalizer_pipe : log-stage mantissa left-normalizer with
//                           valid/ready on both sides, one stage per level.
// Rev 1.0
// ============================================================================
module fp_mant_normalizer_pipe
  import fp_norm_pkg::*;
#(
  parameter int W  = c_W,
  parameter int EW = c_EW,
  parameter int SW = c_SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic [SW-1:0] out_shift,
  output logic          out_zero,
  output logic          out_uflow
);

  // Index k-1 feeds stage k; index SW is the output side.
  logic          w_v     [0:SW];
  logic          w_rdy   [0:SW];
  logic [W-1:0]  w_mant  [0:SW];
  logic [EW-1:0] w_exp   [0:SW];
  logic [SW-1:0] w_shift [0:SW];
  logic          w_zero  [0:SW];
  logic          w_uflow [0:SW];

  assign w_v[0]     = in_valid;
  assign w_mant[0]  = in_mant;
  assign w_exp[0]   = in_exp;
  assign w_shift[0] = '0;
  assign w_zero[0]  = 1'b0;
  assign w_uflow[0] = 1'b0;
  assign in_ready   = w_rdy[0];
  assign w_rdy[SW]  = out_ready;

  generate
    for (genvar k = 1; k <= SW; k++) begin : g_stage
      fp_norm_stage #(
        .W    (W),
        .EW   (EW),
        .SW   (SW),
        .AMT  (stage_amt(W, k)),
        .LAST (k == SW)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_v[k-1]),
        .o_ready (w_rdy[k-1]),
        .i_mant  (w_mant[k-1]),
        .i_exp   (w_exp[k-1]),
        .i_shift (w_shift[k-1]),
        .i_zero  (w_zero[k-1]),
        .i_uflow (w_uflow[k-1]),
        .o_valid (w_v[k]),
        .i_ready (w_rdy[k]),
        .o_mant  (w_mant[k]),
        .o_exp   (w_exp[k]),
        .o_shift (w_shift[k]),
        .o_zero  (w_zero[k]),
        .o_uflow (w_uflow[k])
      );
    end
  endgenerate

  assign out_valid = w_v[SW];
  assign out_mant  = w_mant[SW];
  assign out_exp   = w_exp[SW];
  assign out_shift = w_shift[SW];
  assign out_zero  = w_zero[SW];
  assign out_uflow = w_uflow[SW];

endmodule
`default_nettype wire

// File: tb/tb_fp_mant_normalizer_pipe.sv
`default_nettype none
// ============================================================================
// tb_fp_mant_normalizer_pipe : directed vectors with a scoreboard queue and
//                              a negedge monitor that checks every output.
// Rev 1.0
// ============================================================================
module tb_fp_mant_normalizer_pipe;
  import fp_norm_pkg::*;

  localparam int W  = c_W;
  localparam int EW = c_EW;
  localparam int SW = c_SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_mant;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_shift;
  logic          out_zero;
  logic          out_uflow;

  always #5 clk = ~clk;

  fp_mant_normalizer_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  typedef struct {
    logic [W-1:0]  mant;
    logic [EW-1:0] exp;
    norm_rec_t     r;
    logic          uflow;
  } vec_t;

  typedef struct {
    norm_rec_t r;
    logic      uflow;
    bit        chk_lat;
    int        t0;
  } exp_t;

  vec_t vt [12];
  exp_t q [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   cyc   = 0;
  bit   seen_head = 1'b0;
  bit   saw_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every presented result is checked against the head.
  always @(negedge clk) begin
    logic [W+EW+SW+1:0] got, want;
    if (rst_n && out_valid) begin
      n_cmp++;
      got = {out_mant, out_exp, out_shift, out_zero, out_uflow};
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got mant=%h exp=%0d shift=%0d zero=%0d uflow=%0d, expected no output",
                 out_mant, out_exp, out_shift, out_zero, out_uflow);
      end else begin
        want = {q[0].r, q[0].uflow};
        if (got !== want) begin
          n_err++;
          $display("FAIL result: got mant=%h exp=%0d shift=%0d zero=%0d uflow=%0d, required mant=%h exp=%0d shift=%0d zero=%0d uflow=%0d",
                   out_mant, out_exp, out_shift, out_zero, out_uflow,
                   q[0].r.mant, q[0].r.exp, q[0].r.shift, q[0].r.zero, q[0].uflow);
        end
        if (!seen_head) begin
          seen_head = 1'b1;
          if (q[0].chk_lat) begin
            n_cmp++;
            if (cyc - q[0].t0 != SW) begin
              n_err++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - q[0].t0, SW);
            end
          end
        end
        if (out_ready) begin
          void'(q.pop_front());
          seen_head = 1'b0;
          n_out++;
        end
      end
    end
  end

  task automatic setv(input int i, input logic [W-1:0] m, input logic [EW-1:0] e,
                      input logic [W-1:0] om, input logic [EW-1:0] oe,
                      input logic [SW-1:0] os, input logic oz, input logic ou);
    vt[i].mant    = m;
    vt[i].exp     = e;
    vt[i].r.mant  = om;
    vt[i].r.exp   = oe;
    vt[i].r.shift = os;
    vt[i].r.zero  = oz;
    vt[i].uflow   = ou;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input int idx, input bit lat);
    exp_t e;
    int   guard;
    in_mant  = vt[idx].mant;
    in_exp   = vt[idx].exp;
    in_valid = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!in_ready) begin
      saw_stall = 1'b1;
      guard++;
      if (guard > 100) begin
        $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        $fatal(1, "input never accepted");
      end
      @(negedge clk);
    end
    e.r       = vt[idx].r;
    e.uflow   = vt[idx].uflow;
    e.chk_lat = lat;
    e.t0      = cyc;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, q.size());
    end
    step();
  endtask

  task automatic check_reset(input string name);
    logic [W+EW+SW+3:0] got, want;
    got  = {out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow, in_ready};
    want = {1'b0, {(W+EW+SW+2){1'b0}}, 1'b1};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got valid=%0d mant=%h exp=%0d shift=%0d zero=%0d uflow=%0d in_ready=%0d, required all 0 with in_ready=1",
               name, out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow, in_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    setv(0,  8'h01, 5'd10, 8'h80, 5'd3,  3'd7, 1'b0, 1'b0);
    setv(1,  8'hB3, 5'd5,  8'hB3, 5'd5,  3'd0, 1'b0, 1'b0);
    setv(2,  8'h2C, 5'd9,  8'hB0, 5'd7,  3'd2, 1'b0, 1'b0);
    setv(3,  8'h00, 5'd12, 8'h00, 5'd0,  3'd7, 1'b1, 1'b0);
    setv(4,  8'h10, 5'd2,  8'h80, 5'd0,  3'd3, 1'b0, 1'b1);
    setv(5,  8'h40, 5'd1,  8'h80, 5'd0,  3'd1, 1'b0, 1'b0);
    setv(6,  8'h7F, 5'd20, 8'hFE, 5'd19, 3'd1, 1'b0, 1'b0);
    setv(7,  8'h03, 5'd6,  8'hC0, 5'd0,  3'd6, 1'b0, 1'b0);
    setv(8,  8'h05, 5'd31, 8'hA0, 5'd26, 3'd5, 1'b0, 1'b0);
    setv(9,  8'h00, 5'd3,  8'h00, 5'd0,  3'd7, 1'b1, 1'b0);
    setv(10, 8'h80, 5'd0,  8'h80, 5'd0,  3'd0, 1'b0, 1'b0);
    setv(11, 8'h0F, 5'd0,  8'hF0, 5'd0,  3'd4, 1'b0, 1'b1);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("reset_state");

    // Single beats: lone-one, already-normal, two-bit shift, zero, underflow.
    step();
    send(0, 1'b1);
    in_valid = 1'b0;
    drain("single_lsb");
    send(1, 1'b1);
    send(2, 1'b1);
    in_valid = 1'b0;
    drain("normal_and_shift2");
    send(3, 1'b1);
    in_valid = 1'b0;
    drain("zero");
    send(4, 1'b1);
    send(5, 1'b1);
    in_valid = 1'b0;
    drain("uflow");

    // Ten back-to-back beats with the consumer stalled for five cycles.
    n0        = n_out;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
      end
    join
    drain("stream");
    n_cmp++;
    if (n_out - n0 != 10) begin
      n_err++;
      $display("FAIL stream_count: got %0d beats, required 10", n_out - n0);
    end
    n_cmp++;
    if (!saw_stall) begin
      n_err++;
      $display("FAIL stream_backpressure: in_ready never dropped, required a drop");
    end

    // Reset with three beats in flight, then fresh beats at full latency.
    out_ready = 1'b0;
    send(6, 1'b0);
    send(7, 1'b0);
    send(8, 1'b0);
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    seen_head = 1'b0;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("midflight_reset");
    step();
    send(10, 1'b1);
    send(11, 1'b1);
    in_valid = 1'b0;
    drain("post_reset");
    send(9, 1'b1);
    in_valid = 1'b0;
    drain("zero_borrow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
